// File: rtl/mult_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
//   WIDTH   : operand width (only 32 is supported)
//   ITER    : number of Booth steps per multiply (one per multiplier bit)
//   COUNT_W : width of the step counter
//   state_t : controller states
//   booth_op_t / booth_decode : accumulator operation chosen by the
//             multiplier bit pair {P[1], P[0]}
package mult_pkg;

  localparam int WIDTH   = 32;
  localparam int ITER    = 32;
  localparam int COUNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding: 01 marks the end of a run of ones (add M),
  // 10 marks the start of a run of ones (subtract M).
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    case (pair)
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step.
//   p      : working register {accumulator[WIDTH:0], multiplier[WIDTH-1:0], guard}
//   m      : sign-extended multiplicand (WIDTH+1 bits)
//   p_next : p after the add/subtract and a 1-bit arithmetic right shift
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH+1:0] p,
  input  logic [WIDTH:0]     m,
  output logic [2*WIDTH+1:0] p_next
);
  import mult_pkg::*;

  logic [WIDTH:0] acc;
  logic [WIDTH:0] acc_new;
  booth_op_t      op;

  always_comb begin
    acc     = p[2*WIDTH+1:WIDTH+1];
    op      = booth_decode(p[1:0]);
    acc_new = acc;
    case (op)
      OP_ADD:  acc_new = acc + m;
      OP_SUB:  acc_new = acc - m;
      default: acc_new = acc;
    endcase
    // Arithmetic shift of the whole register: the accumulator sign bit is
    // replicated into the top and the old guard bit drops off the bottom.
    p_next = {acc_new[WIDTH], acc_new, p[WIDTH:1]};
  end

endmodule

// File: rtl/mult_booth.sv
// Multi-cycle signed radix-2 Booth multiplier (WIDTH x WIDTH).
//   clock          : rising-edge clock
//   reset_n        : asynchronous active-low reset
//   ctrl_MULT      : start strobe; relatches operands in any state
//   data_operandA  : multiplicand, two's complement
//   data_operandB  : multiplier, two's complement
//   data_result    : low WIDTH bits of the product (held until next completion)
//   data_exception : product does not fit in a signed WIDTH-bit result
//   data_resultRDY : one-cycle pulse when data_result/data_exception update
//   busy           : high while Booth steps are running
//   dbg_state      : current controller state, for observation only
//
// Handshake: a start is taken on any rising edge with ctrl_MULT high; there
// is no ready/backpressure on the start side. The result side is a pure
// valid pulse (data_resultRDY) with no ready: the consumer must capture the
// result in the cycle the pulse is high, or read the held data_result later.
// A start while an operation is in flight abandons it without a pulse.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ctrl_MULT,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy,
  output mult_pkg::state_t   dbg_state
);
  import mult_pkg::*;

  localparam int P_W = 2 * WIDTH + 2;
  localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(ITER - 1);

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [P_W-1:0]       p_q, p_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, rdy_d;
  logic [P_W-1:0]       p_step;
  logic [WIDTH:0]       high_bits;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_q),
    .m      (m_q),
    .p_next (p_step)
  );

  // Product bits [2*WIDTH-1:WIDTH-1] live at P[2*WIDTH:WIDTH]; the result
  // fits in WIDTH signed bits only when they are all equal.
  assign high_bits = p_q[2*WIDTH:WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      p_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      p_q      <= p_d;
      m_q      <= m_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    p_d      = p_q;
    m_d      = m_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (ctrl_MULT) begin
      // A start wins in every state; an in-flight product is dropped.
      m_d     = {data_operandA[WIDTH-1], data_operandA};
      p_d     = {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
      count_d = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          p_d     = p_step;
          count_d = count_q + 1'b1;
          if (count_q == LAST_STEP) state_d = DONE;
        end
        DONE: begin
          result_d = p_q[WIDTH:1];
          exc_d    = ~((&high_bits) | ~(|high_bits));
          rdy_d    = 1'b1;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == RUN);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mult_booth.sv
module tb_mult_booth;
  import mult_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  state_t      dbg_state;

  int errors;
  int checks;

  mult_booth #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Strobe a start for exactly one rising edge (call at a falling edge).
  // Afterwards the operand buses carry junk to show they are ignored.
  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    cycle();
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Count edges after the start edge until RDY shows; bounded.
  task automatic wait_rdy(input string tag, input int exp_latency);
    int n;
    n = 0;
    while (!data_resultRDY && n < 80) begin
      cycle();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_latency));
  endtask

  task automatic expect_result(input string tag, input logic [31:0] r, input logic e);
    wait_rdy(tag, 33);
    check({tag, "_result"}, 64'(data_result), 64'(r));
    check({tag, "_exc"}, 64'(data_exception), 64'(e));
    check({tag, "_busy_done"}, 64'(busy), 64'(0));
    cycle();
    check({tag, "_rdy_one_cycle"}, 64'(data_resultRDY), 64'(0));
    check({tag, "_result_hold"}, 64'(data_result), 64'(r));
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    repeat (3) @(negedge clock);
    check("reset_result", 64'(data_result), 64'(0));
    check("reset_exc", 64'(data_exception), 64'(0));
    check("reset_rdy", 64'(data_resultRDY), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    reset_n = 1'b1;
    cycle();

    // 3 x 5
    pulse_start(32'd3, 32'd5);
    check("run_busy", 64'(busy), 64'(1));
    check("run_state", 64'(dbg_state), 64'(RUN));
    expect_result("p3x5", 32'h0000_000F, 1'b0);

    // -7 x 6
    pulse_start(32'hFFFF_FFF9, 32'd6);
    expect_result("m7x6", 32'hFFFF_FFD6, 1'b0);

    // -2^31 x -1 overflows to +2^31
    pulse_start(32'h8000_0000, 32'hFFFF_FFFF);
    expect_result("min_x_m1", 32'h8000_0000, 1'b1);

    // -2^31 x 1 fits exactly
    pulse_start(32'h8000_0000, 32'd1);
    expect_result("min_x_1", 32'h8000_0000, 1'b0);

    // (2^31-1) x 2 = 2^32-2
    pulse_start(32'h7FFF_FFFF, 32'd2);
    expect_result("max_x_2", 32'hFFFF_FFFE, 1'b1);

    // 2^16 x 2^16 = 2^32
    pulse_start(32'h0001_0000, 32'h0001_0000);
    expect_result("p16_sq", 32'h0000_0000, 1'b1);

    // (2^31-1)^2 = 2^62 - 2^32 + 1
    pulse_start(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    expect_result("max_sq", 32'h0000_0001, 1'b1);

    // -1 x -1
    pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_result("m1_sq", 32'h0000_0001, 1'b0);

    // Restart at edge 10 with 4 x 4: RDY only 33 edges after the restart.
    pulse_start(32'd3, 32'd5);
    repeat (9) cycle();
    pulse_start(32'd4, 32'd4);
    check("restart_busy", 64'(busy), 64'(1));
    expect_result("restart", 32'd16, 1'b0);

    // Back-to-back: start in the cycle RDY is high; both results arrive.
    pulse_start(32'd7, 32'd9);
    wait_rdy("b2b_first", 33);
    check("b2b_first_result", 64'(data_result), 64'(63));
    pulse_start(32'hFFFF_FFFE, 32'd100);
    check("b2b_second_busy", 64'(busy), 64'(1));
    expect_result("b2b_second", 32'hFFFF_FF38, 1'b0);

    // Reset mid-run: outputs clear immediately, no RDY afterwards.
    pulse_start(32'd3, 32'd5);
    repeat (12) cycle();
    reset_n = 1'b0;
    #1;
    check("midrst_result", 64'(data_result), 64'(0));
    check("midrst_exc", 64'(data_exception), 64'(0));
    check("midrst_rdy", 64'(data_resultRDY), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clock);
    repeat (2) cycle();
    reset_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        cycle();
        if (data_resultRDY) seen++;
      end
      check("midrst_no_rdy", 64'(seen), 64'(0));
    end
    pulse_start(32'd2, 32'd2);
    expect_result("after_rst", 32'd4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
